// File: rtl/program_loader.sv
// Boot loader: big-endian 16-bit words from a UART byte stream go to consecutive memory words while the core is held in reset.
// A word is written one cycle after its low byte; no backpressure, so stray bytes are dropped. Option: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter logic [15:0] BASE_ADDR      = 16'h0000,
   parameter int          DEPTH          = 4096,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic [15:0] mem_address,
   output logic [15:0] mem_data,
   output logic        mem_wren,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_written
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR,
                             CSUM_HI, CSUM_LO} state_t;
`else
   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR} state_t;
`endif

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0] DEPTH_MAX    = 17'(DEPTH);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] len;
   logic        len_rdy;
   logic [7:0]  hi_byte;
   logic [31:0] idle_cnt;
   logic        idle_state;
   logic        rx_state;
   logic        len_zero;
   logic        len_over;
   logic        last_word;
   logic        timed_out;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [15:0] csum;
`endif

   assign idle_state = (state == IDLE) || (state == DONE) || (state == ERROR);
   assign rx_state   = !idle_state && (state != WRITE);
   assign len_zero   = (len == 16'd0);
   assign len_over   = ({1'b0, len} > DEPTH_MAX);
   assign last_word  = ((words_written + 16'd1) == len);
   assign timed_out  = rx_state && !rx_valid && (idle_cnt == TIMEOUT_LAST);

   assign busy     = !idle_state;
   assign cpu_hold = !idle_state;
   assign done     = (state == DONE);
   assign error    = (state == ERROR);
   assign mem_wren = (state == WRITE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The length is judged one cycle after its low byte; a byte arriving in that
   // cycle is already the next high byte and is kept rather than lost.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERROR: if (load_start) state_nxt = LEN_HI;
         LEN_HI:  if (rx_valid) state_nxt = LEN_LO;
         LEN_LO: begin
            if (len_rdy) begin
               if (len_zero) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state_nxt = rx_valid ? CSUM_LO : CSUM_HI;
`else
                  state_nxt = DONE;
`endif
               end else if (len_over) begin
                  state_nxt = ERROR;
               end else begin
                  state_nxt = rx_valid ? DATA_LO : DATA_HI;
               end
            end
         end
         DATA_HI: if (rx_valid) state_nxt = DATA_LO;
         DATA_LO: if (rx_valid) state_nxt = WRITE;
         WRITE: begin
            if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_nxt = rx_valid ? CSUM_LO : CSUM_HI;
`else
               state_nxt = DONE;
`endif
            end else begin
               state_nxt = rx_valid ? DATA_LO : DATA_HI;
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CSUM_HI: if (rx_valid) state_nxt = CSUM_LO;
         CSUM_LO: if (rx_valid) state_nxt = ({hi_byte, rx_data} == csum) ? DONE : ERROR;
`endif
         default: state_nxt = IDLE;
      endcase
      if (timed_out && (state_nxt == state)) state_nxt = ERROR;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_address   <= BASE_ADDR;
         mem_data      <= '0;
         words_written <= '0;
         len           <= '0;
         len_rdy       <= 1'b0;
         hi_byte       <= '0;
         idle_cnt      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum          <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (load_start) begin
                  mem_address   <= BASE_ADDR;
                  words_written <= '0;
                  len_rdy       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum          <= '0;
`endif
               end
            end
            LEN_HI: if (rx_valid) len[15:8] <= rx_data;
            LEN_LO: begin
               if (rx_valid) begin
                  if (!len_rdy) begin
                     len[7:0] <= rx_data;
                     len_rdy  <= 1'b1;
                  end else begin
                     hi_byte  <= rx_data;
                  end
               end
            end
            DATA_HI: if (rx_valid) hi_byte <= rx_data;
            DATA_LO: if (rx_valid) mem_data <= {hi_byte, rx_data};
            WRITE: begin
               mem_address   <= mem_address + 16'd1;
               words_written <= words_written + 16'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum          <= csum + mem_data;
`endif
               if (rx_valid) hi_byte <= rx_data;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM_HI: if (rx_valid) hi_byte <= rx_data;
`endif
            default: ;
         endcase

         // Held at zero while idle, so every load starts its timeout afresh.
         if (idle_state)    idle_cnt <= '0;
         else if (rx_valid) idle_cnt <= '0;
         else if (rx_state) idle_cnt <= idle_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a transaction-level write/status model plus hand-computed literal expectations.
module tb_program_loader;
   localparam logic [15:0] BASE  = 16'h0100;
   localparam int          DEPTH = 8;
   localparam int          TMO   = 40;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [15:0] mem_address;
   logic [15:0] mem_data;
   logic        mem_wren;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] wq[$];
   logic [15:0] exp_addr[$];
   logic [15:0] exp_data[$];
   logic        m_done;
   logic        m_err;
   logic [15:0] m_ww;
   int          wr_count = 0;
   logic [15:0] last_addr = '0;
   logic [15:0] last_data = '0;
   logic        prev_wren = 1'b0;

   program_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .load_start(load_start), .rx_valid(rx_valid),
      .rx_data(rx_data), .mem_address(mem_address), .mem_data(mem_data),
      .mem_wren(mem_wren), .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .error(error), .words_written(words_written)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic start_pulse();
      load_start = 1'b1;
      tick(1);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick(gap);
   endtask

   // Expected writes and final status for a load of wq with length field n.
   task automatic model_load(input logic [15:0] n, input logic [15:0] cs);
      logic [15:0] s;
      s = '0;
      exp_addr.delete();
      exp_data.delete();
      wr_count = 0;
      m_ww   = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (n > DEPTH) begin
         m_err = 1'b1;
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(BASE + 16'(i));
            exp_data.push_back(wq[i]);
            s = s + wq[i];
         end
         m_ww = n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         m_done = (s == cs);
         m_err  = (s != cs);
`else
         m_done = 1'b1;
`endif
      end
   endtask

   task automatic check_model();
      chk("model_done", done, m_done);
      chk("model_error", error, m_err);
      chk("model_words_written", words_written, m_ww);
      chk("model_busy_low", busy, 1'b0);
      chk("model_hold_low", cpu_hold, 1'b0);
      chk("model_writes_outstanding", exp_addr.size(), 0);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         tick(1);
         k++;
      end
      chk("idle_within_budget", busy, 1'b0);
   endtask

   task automatic run_load(input logic [15:0] n, input logic [15:0] cs, input int gap, input int inject);
      model_load(n, cs);
      start_pulse();
      send_byte(n[15:8], gap);
      send_byte(n[7:0], gap);
      if (n <= DEPTH) begin
         for (int i = 0; i < int'(n); i++) begin
            if (i == inject) load_start = 1'b1;
            send_byte(wq[i][15:8], 0);
            load_start = 1'b0;
            tick(gap);
            send_byte(wq[i][7:0], gap);
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         send_byte(cs[15:8], gap);
         send_byte(cs[7:0], gap);
`endif
      end
      wait_idle(50);
      check_model();
   endtask

   always @(negedge clock) begin
      if (reset) begin
         prev_wren = 1'b0;
      end else begin
         chk("hold_vs_busy", cpu_hold, busy);
         chk("done_error_exclusive", done & error, 1'b0);
         chk("wren_outside_load", mem_wren & ~busy, 1'b0);
         chk("wren_pulse_width", mem_wren & prev_wren, 1'b0);
         if (mem_wren) begin
            wr_count++;
            last_addr = mem_address;
            last_data = mem_data;
            chk("write_expected", exp_addr.size() > 0, 1'b1);
            if (exp_addr.size() > 0) begin
               chk("write_addr", mem_address, exp_addr.pop_front());
               chk("write_data", mem_data, exp_data.pop_front());
            end
         end
         prev_wren = mem_wren;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "bench watchdog");
   end

   initial begin
      reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      tick(3);
      reset = 1'b0;
      chk("rst_mem_address", mem_address, 16'h0100);
      chk("rst_mem_data", mem_data, 16'h0000);
      chk("rst_wren", mem_wren, 1'b0);
      chk("rst_hold", cpu_hold, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_words", words_written, 16'h0000);

      // 00 03 12 34 AB CD C0 F0
      wq.delete();
      wq.push_back(16'h1234); wq.push_back(16'hABCD); wq.push_back(16'hC0F0);
      run_load(16'd3, 16'h7EF1, 2, -1);
      chk("n3_write_count", wr_count, 3);
      chk("n3_last_addr", last_addr, 16'h0102);
      chk("n3_last_data", last_data, 16'hC0F0);
      chk("n3_done", done, 1'b1);
      chk("n3_words", words_written, 16'd3);

      // Empty load
      wq.delete();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      run_load(16'd0, 16'h0000, 1, -1);
`else
      model_load(16'd0, 16'h0000);
      start_pulse();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("n0_done_early", done, 1'b0);
      tick(1);
      chk("n0_done_two_cycles", done, 1'b1);
      check_model();
`endif
      chk("n0_words", words_written, 16'd0);
      chk("n0_no_writes", wr_count, 0);

      // Oversized length
      wq.delete();
      run_load(16'(DEPTH + 1), 16'h0000, 1, -1);
      chk("over_error", error, 1'b1);
      chk("over_hold", cpu_hold, 1'b0);
      chk("over_no_writes", wr_count, 0);

      // Stall after one high byte
      exp_addr.delete(); exp_data.delete();
      wr_count = 0; m_done = 1'b0; m_err = 1'b1; m_ww = '0;
      start_pulse();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      tick(TMO - 1);
      chk("stall_no_error_early", error, 1'b0);
      chk("stall_busy_early", busy, 1'b1);
      tick(1);
      chk("stall_error", error, 1'b1);
      check_model();
      chk("stall_no_writes", wr_count, 0);

      // Back-to-back bytes with a stray load_start mid-load
      wq.delete();
      wq.push_back(16'h1111); wq.push_back(16'h2222); wq.push_back(16'h3333); wq.push_back(16'h4444);
      run_load(16'd4, 16'hAAAA, 0, 1);
      chk("b2b_write_count", wr_count, 4);
      chk("b2b_last_addr", last_addr, 16'h0103);
      chk("b2b_last_data", last_data, 16'h4444);
      chk("b2b_words", words_written, 16'd4);
      chk("b2b_error_cleared", error, 1'b0);

      // Reset mid-load keeps the partial write and returns to idle
      model_load(16'd4, 16'hAAAA);
      start_pulse();
      send_byte(8'h00, 1);
      send_byte(8'h04, 1);
      send_byte(8'h11, 0);
      send_byte(8'h11, 2);
      send_byte(8'h22, 0);
      reset = 1'b1;
      tick(1);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_hold", cpu_hold, 1'b0);
      chk("rstmid_words", words_written, 16'd0);
      chk("rstmid_addr", mem_address, 16'h0100);
      chk("rstmid_partial_writes", wr_count, 1);
      reset = 1'b0;
      exp_addr.delete(); exp_data.delete();
      tick(1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      wq.delete();
      wq.push_back(16'h0001); wq.push_back(16'hFFFF);
      run_load(16'd2, 16'h0000, 1, -1);
      chk("csum_ok_done", done, 1'b1);
      run_load(16'd2, 16'h0001, 1, -1);
      chk("csum_bad_error", error, 1'b1);
      chk("csum_bad_words", words_written, 16'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream bootloader that fills main memory with a program before the processor runs.
- It is the writer side of the instruction/data memory path that the processor core only reads during fetch.
- Takes a byte stream from a UART receiver, assembles 16-bit big-endian words and writes them to consecutive memory addresses.
- Holds the core in reset for the whole load; its write port is muxed ahead of the core's memory port while cpu_hold is high.

Parameters:
- BASE_ADDR, 16'h0000, memory address of the first loaded word.
- DEPTH, 4096, maximum number of words accepted in one load.
- TIMEOUT_CYCLES, 1000000, maximum idle clock cycles between bytes before the load aborts.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  single-cycle pulse that begins a load.
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle.
- rx_data  input  8  received byte.
- mem_address  output  16  write address to main memory.
- mem_data  output  16  write data to main memory.
- mem_wren  output  1  memory write enable; high for exactly one cycle per word.
- cpu_hold  output  1  high for the whole load; ORed into the core's reset.
- busy  output  1  load in progress.
- done  output  1  sticky; load completed successfully.
- error  output  1  sticky; load aborted.
- words_written  output  16  number of words written in the current or last load.

Behaviour:
- Reset: state IDLE. mem_address=BASE_ADDR. mem_data=0. mem_wren, cpu_hold, busy, done, error all 0. words_written=0. Timeout counter 0.
- Reset asserted mid-load returns to IDLE immediately; the partial memory contents are left as written.
- Stream format: length word N (hi byte, then lo byte), then N data words (hi byte, then lo byte each).
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR (CSUM_HI and CSUM_LO only with the optional feature).
- IDLE/DONE/ERROR + load_start:
  - go to LEN_HI;
  - clear done, error and words_written;
  - set mem_address=BASE_ADDR;
  - set busy=1 and cpu_hold=1.
- load_start while busy is ignored. rx_valid in IDLE/DONE/ERROR is ignored.
- LEN_HI/LEN_LO: each rx_valid captures one byte of N.
- Leaving LEN_LO:
  - N=0: go to DONE, no writes.
  - N>DEPTH: go to ERROR, no writes.
  - Otherwise: go to DATA_HI.
- DATA_HI: rx_valid captures the high byte.
- DATA_LO: rx_valid loads mem_data={hi,rx_data} and goes to WRITE.
- WRITE lasts one cycle:
  - mem_wren=1 with mem_address/mem_data stable (memory samples on the falling edge);
  - on exit, mem_address+1 and words_written+1 (16-bit wrap);
  - then to DONE if words_written reaches N, else to DATA_HI.
- An rx_valid arriving during WRITE while words remain is captured as the next high byte, and the block goes straight to DATA_LO.
- Timeout: counter clears on every rx_valid and on entry to LEN_HI. It increments in every receive state. Reaching TIMEOUT_CYCLES goes to ERROR.
- DONE: done=1, busy=0, cpu_hold=0.
- ERROR: error=1, busy=0, cpu_hold=0.
- mem_wren is never high outside WRITE.
- Bytes per load: 2+2N without the optional feature.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined: after the last data word, the stream carries one checksum word (hi, lo) in states CSUM_HI and CSUM_LO.
  - Checksum = 16-bit modulo-2^16 sum of all N data words.
  - Match: go to DONE. Mismatch: go to ERROR.
  - Memory writes already made remain; words_written=N.
  - N=0 still expects a checksum word of 0x0000.
  - The timeout applies in CSUM states.
- Undefined: CSUM states and the sum register are absent; DONE follows the last WRITE directly.

Test Plan:
- Load N=3 (bytes 00 03 12 34 AB CD C0 F0):
  - exactly three single-cycle mem_wren pulses: addr 0→0x1234, 1→0xABCD, 2→0xC0F0;
  - done=1, words_written=3, cpu_hold falls at DONE.
- N=0 (bytes 00 00): no mem_wren; done=1 two cycles after the second byte; words_written=0.
- N=DEPTH+1: error=1 after the length word; no mem_wren; busy=0; cpu_hold=0.
- Stall: send 00 02 11, then stop for TIMEOUT_CYCLES cycles → error=1, no writes. A following load_start clears error and a new load succeeds.
- Back-to-back: the next hi byte arrives during WRITE → accepted; 4-word load at BASE_ADDR=0x0100 writes 0x0100..0x0103. A load_start mid-load is ignored.
- With PROGRAM_LOADER_CHECKSUM_EN:
  - words 0x0001, 0xFFFF with checksum 0x0000 → done=1;
  - same words with checksum 0x0001 → error=1, words_written=2.
